sys_array_sequencer: RTL and testbench
======================================

# sys_array_sequencer

Job-level controller that sequences one `sys_array_fetcher` instance. Accepts matrix-multiply jobs (operand matrices A and B) over a valid/ready handshake, drives the fetcher's `load_params` / `start_comp` protocol, waits for completion and returns the registered W×W result over a second valid/ready handshake. Sits between the host/DMA side and the fetcher, so upstream logic never toggles fetcher control pins directly.

## Interface
- `DATA_WIDTH`, 8, operand element width; result elements are 2*DATA_WIDTH.
- `ARRAY_W`, 5, rows of A and B; the result is ARRAY_W×ARRAY_W.
- `ARRAY_L`, 2, columns of A and B (inner dimension).
- `START_HOLD`, 6, cycles `fa_start_comp` is held high; must be ≥1.
- `TIMEOUT_CYCLES`, 1024, watchdog limit in the WAIT states; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  sequencer can accept a job.
- `job_a`, `job_b`  in  [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  operands, sampled on acceptance.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]  result matrix.
- `res_err`  out  1  result invalid (timeout); qualified by `res_valid`.
- `busy`  out  1  high in every state except IDLE.
- `fa_load_params`, `fa_start_comp`  out  1  fetcher controls.
- `fa_input_data_a`, `fa_input_data_b`  out  same shape as `job_a`  registered operands.
- `fa_ready`  in  1  fetcher idle/finished.
- `fa_out_data`  in  same shape as `res_data`  fetcher result.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RESULT.
- IDLE: `job_ready=1`. On `job_valid && job_ready`, register `job_a`/`job_b` into the `fa_input_data_*` registers and go to LOAD.
- LOAD: `fa_load_params=1` for exactly one cycle, then go to START.
- START: `fa_start_comp=1` for START_HOLD cycles, counted by `hold_cnt`. If `fa_ready` is seen low in any START cycle, set the `seen_busy` flag. After the last hold cycle, go to WAIT_DONE if `seen_busy` is set, else to WAIT_BUSY.
- WAIT_BUSY: wait for `fa_ready==0`, then go to WAIT_DONE.
- WAIT_DONE: wait for `fa_ready==1`. On that cycle capture `fa_out_data` into `res_data`, clear `res_err`, and go to RESULT.
- RESULT: `res_valid=1`, with `res_data`/`res_err` stable. On `res_ready`, go to IDLE. `job_ready` is low in RESULT, so there are no back-to-back overlapping jobs.
- Operand registers hold their value until the next acceptance.
- Reset from any state: go to IDLE; clear the counters and `seen_busy`. `res_data` and the operand registers are zeroed.

## Timing
- Reset values: `job_ready=1`, `res_valid=0`, `res_err=0`, `busy=0`, `fa_load_params=0`, `fa_start_comp=0`, `res_data=0`, `fa_input_data_*=0`.
- Acceptance in cycle t gives:
  - `fa_load_params` high in cycle t+1.
  - `fa_start_comp` high in cycles t+2 … t+1+START_HOLD.
- `res_valid` rises the cycle after `fa_ready` is sampled high in WAIT_DONE.
- Minimum accept-to-`res_valid` latency is START_HOLD+3 cycles, when the fetcher drops `fa_ready` during START and raises it in the first WAIT_DONE cycle.
- All outputs are registered; there are no combinational input-to-output paths, including `job_ready`.
- If `res_ready` is already high when `res_valid` rises, the handshake completes in that cycle and IDLE is reached on the next cycle.
- `job_valid` while busy is ignored; the job is neither accepted nor lost and stays pending upstream.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in WAIT_BUSY+WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to RESULT with `res_err=1` and `res_data` unchanged from its previous value.
  - The watchdog clears on entering LOAD.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter is present and `res_err` is tied to 0.
  - The WAIT states wait indefinitely.

## Structure
- A shared package `sys_array_pkg` holds:
  - the state enum `seq_state_t`;
  - typedefs for the operand and result matrix types, parameterised through package parameters mirroring DATA_WIDTH/ARRAY_W/ARRAY_L;
  - the default `TIMEOUT_CYCLES`.
- A single flat module; no sub-module is needed. The optional watchdog is an inline `ifdef` block.

## Test plan
- **Basic job:** reset, then submit A=B with elements i*2+j+1 (values 1..10, W=5, L=2) against a behavioural fetcher model computing A·Bᵀ. Required: `fa_load_params` high only in t+1, and `fa_start_comp` high in t+2…t+7. `res_data[0][0]=5`, `res_data[4][4]=181`, `res_err=0`.
- **Backpressure:** hold `res_ready=0` for 20 cycles. Required: `res_valid`/`res_data` stable, `job_ready=0`, and a second `job_valid` is not accepted until the result is taken.
- **Fast fetcher:** the model drops `fa_ready` in the 2nd START cycle. Required: the FSM skips WAIT_BUSY and `res_valid` arrives START_HOLD+3 cycles after acceptance when `fa_ready` returns immediately.
- **Slow fetcher:** `fa_ready` stays high through START and drops 10 cycles later. Required: the FSM stays in WAIT_BUSY, then completes normally.
- **Reset mid-job:** assert `reset` during START. Required: next cycle all outputs are at reset values, and a fresh job then completes correctly.
- **Timeout (`SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=64):** the model never drops `fa_ready`. Required: `res_valid=1` with `res_err=1` 64 cycles after entering WAIT_BUSY.

Source files
------------

// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared FSM state, default sizes and matrix types for the systolic-array sequencer
package sys_array_pkg;
  localparam int SA_DATA_WIDTH     = 8;
  localparam int SA_ARRAY_W        = 5;
  localparam int SA_ARRAY_L        = 2;
  localparam int SA_START_HOLD     = 6;
  localparam int SA_TIMEOUT_CYCLES = 1024;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RESULT} seq_state_t;
  typedef logic [0:SA_ARRAY_W-1][0:SA_ARRAY_L-1][SA_DATA_WIDTH-1:0]   op_mat_t;
  typedef logic [0:SA_ARRAY_W-1][0:SA_ARRAY_W-1][2*SA_DATA_WIDTH-1:0] res_mat_t;
endpackage

// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer: job-level controller for one sys_array_fetcher; define SEQ_TIMEOUT_EN to add the WAIT-state watchdog
module sys_array_sequencer
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH     = SA_DATA_WIDTH,
  parameter int ARRAY_W        = SA_ARRAY_W,
  parameter int ARRAY_L        = SA_ARRAY_L,
  parameter int START_HOLD     = SA_START_HOLD,
  parameter int TIMEOUT_CYCLES = SA_TIMEOUT_CYCLES
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               job_valid,
  output logic                                               job_ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    job_a,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    job_b,
  output logic                                               res_valid,
  input  logic                                               res_ready,
  output logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]  res_data,
  output logic                                               res_err,
  output logic                                               busy,
  output logic                                               fa_load_params,
  output logic                                               fa_start_comp,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    fa_input_data_a,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    fa_input_data_b,
  input  logic                                               fa_ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]  fa_out_data
);
  localparam int HW = $clog2(START_HOLD + 1);
  if (START_HOLD < 1) $error("START_HOLD must be at least 1");
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  typedef logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]   op_t;
  typedef logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] res_t;
  seq_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          seen_q, seen_d;
  logic          done, timeout, waiting;
  op_t           a_q, b_q;
  res_t          res_q;
  logic          job_ready_q, busy_q, load_q, start_q, valid_q;
  assign waiting         = state_q == WAIT_BUSY || state_q == WAIT_DONE;
  assign done            = state_q == WAIT_DONE && fa_ready;
  assign job_ready       = job_ready_q;
  assign busy            = busy_q;
  assign fa_load_params  = load_q;
  assign fa_start_comp   = start_q;
  assign res_valid       = valid_q;
  assign res_data        = res_q;
  assign fa_input_data_a = a_q;
  assign fa_input_data_b = b_q;
`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q;
  // watchdog: restarts in LOAD, counts every WAIT cycle, fires unless the fetcher finishes that same cycle
  always_comb begin
    wd_d    = state_q == LOAD ? 16'd0 : waiting ? wd_q + 16'd1 : wd_q;
    timeout = waiting && !done && wd_d == 16'(TIMEOUT_CYCLES);
  end
  // watchdog count and sticky error flag, cleared by a real capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= timeout ? 1'b1 : done ? 1'b0 : err_q;
    end
  end
  assign res_err = err_q;
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif
  // next-state: one LOAD pulse, START_HOLD start cycles, then wait for the fetcher's busy/idle edges
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    seen_d  = seen_q;
    case (state_q)
      IDLE:      if (job_valid) state_d = LOAD;
      LOAD: begin
        state_d = START;
        hold_d  = '0;
        seen_d  = 1'b0;
      end
      START: begin
        hold_d = hold_q + 1'b1;
        seen_d = seen_q | ~fa_ready;
        if (hold_q == HW'(START_HOLD - 1)) state_d = seen_d ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: if (!fa_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (fa_ready) state_d = RESULT;
      RESULT:    if (res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = RESULT;
  end
  // state, counters and outputs registered from the next state so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      seen_q      <= 1'b0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      seen_q      <= seen_d;
      job_ready_q <= state_d == IDLE;
      busy_q      <= state_d != IDLE;
      load_q      <= state_d == LOAD;
      start_q     <= state_d == START;
      valid_q     <= state_d == RESULT;
    end
  end
  // operand registers load on acceptance; result register loads when the fetcher reports done
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (state_q == IDLE && job_valid) begin
        a_q <= job_a;
        b_q <= job_b;
      end
      if (done) res_q <= fa_out_data;
    end
  end
endmodule

// File: tb/tb_sys_array_sequencer.sv
// tb_sys_array_sequencer: directed jobs against a timing/arithmetic model of the sequencer and a behavioural fetcher
module tb_sys_array_sequencer;
  localparam int DW = 8, W = 5, L = 2, H = 6, TO = 64, RW = 2 * DW;
  typedef logic [0:W-1][0:L-1][DW-1:0] op_t;
  typedef logic [0:W-1][0:W-1][RW-1:0] res_t;
  typedef logic [W*W*RW-1:0]           big_t;
  logic clk = 1'b0, reset = 1'b1, job_valid = 1'b0, res_ready = 1'b1, fa_ready = 1'b1;
  logic job_ready, res_valid, res_err, busy, fa_load_params, fa_start_comp;
  op_t  job_a = '0, job_b = '0, fa_input_data_a, fa_input_data_b;
  res_t res_data, fa_out_data;
  int   cyc = 0, errors = 0, checks = 0;
  int   t = 0, d = 0, r = 0, v = 0, x = 0, rr = 0;
  int   rv_cyc = 0, load_cyc = 0, load_cnt = 0, start_cnt = 0;
  logic act = 1'b0, chk_en = 1'b0, exp_err = 1'b0, rv_prev = 1'b0, e_idle, e_rv;
  op_t  ops_a = '0, ops_b = '0;
  res_t res_prev = '0, res_new = '0;

  sys_array_sequencer #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L), .START_HOLD(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy),
    .fa_load_params(fa_load_params), .fa_start_comp(fa_start_comp), .fa_input_data_a(fa_input_data_a),
    .fa_input_data_b(fa_input_data_b), .fa_ready(fa_ready), .fa_out_data(fa_out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mm(op_t a, op_t b);
    res_t m;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        m[i][j] = '0;
        for (int k = 0; k < L; k++) m[i][j] = m[i][j] + RW'(a[i][k]) * RW'(b[j][k]);
      end
    return m;
  endfunction

  always_comb fa_out_data = mm(fa_input_data_a, fa_input_data_b);

  task automatic chk(string n, big_t got, big_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
    end
  endtask

  // per-cycle compare against the job timeline, plus event capture for the literal checks
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      e_idle = !act || cyc <= t || cyc > x;
      e_rv   = act && cyc >= v && cyc <= x;
      chk("job_ready", big_t'(job_ready), big_t'(e_idle));
      chk("busy", big_t'(busy), big_t'(!e_idle));
      chk("load_params", big_t'(fa_load_params), big_t'(act && cyc == t + 1));
      chk("start_comp", big_t'(fa_start_comp), big_t'(act && cyc >= t + 2 && cyc <= t + 1 + H));
      chk("res_valid", big_t'(res_valid), big_t'(e_rv));
      chk("res_data", big_t'(res_data), big_t'((act && cyc >= v) ? res_new : res_prev));
      chk("input_a", big_t'(fa_input_data_a), big_t'(ops_a));
      chk("input_b", big_t'(fa_input_data_b), big_t'(ops_b));
      if (e_rv) chk("res_err", big_t'(res_err), big_t'(exp_err));
    end
    if (fa_load_params === 1'b1) begin
      load_cnt++;
      load_cyc = cyc;
    end
    if (fa_start_comp === 1'b1) start_cnt++;
    if (res_valid === 1'b1 && !rv_prev) rv_cyc = cyc;
    rv_prev = res_valid === 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    fa_ready  = !(act && cyc >= d && cyc < r);
    res_ready = !(act && cyc < rr);
  endtask

  task automatic submit(op_t a, op_t b, int doff, int low, int rrel);
    int n = 0;
    job_a = a;
    job_b = b;
    job_valid = 1'b1;
    while (act && cyc <= x && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_wait cyc=%0d got=busy exp=idle", cyc);
    end
    res_prev = (act && cyc >= v) ? res_new : res_prev;
    t = cyc;
    res_new = mm(a, b);
    exp_err = 1'b0;
    ops_a = a;
    ops_b = b;
    d = t + 2 + doff;
    r = d + low;
    v = (d <= t + 1 + H) ? ((t + 2 + H > r ? t + 2 + H : r) + 1) : r + 1;
`ifdef SEQ_TIMEOUT_EN
    if (v > t + 2 + H + TO) begin
      v = t + 2 + H + TO;
      exp_err = 1'b1;
      res_new = res_prev;
    end
`endif
    rr = rrel == 0 ? 0 : v + rrel;
    x = rr > v ? rr : v;
    act = 1'b1;
    load_cnt = 0;
    start_cnt = 0;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic finish_job();
    int n = 0;
    while (cyc <= x + 1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL job_done_wait cyc=%0d got=pending exp=done", cyc);
    end
  endtask

  initial begin
    op_t a1, a2, b2, a6;
    int v2;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < L; j++) begin
        a1[i][j] = DW'(i * 2 + j + 1);
        a2[i][j] = DW'(3 * i + 7 * j + 2);
        b2[i][j] = DW'(200 - 11 * i - 5 * j);
        a6[i][j] = DW'(17 * i + 29 * j + 250);
      end
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("reset_job_ready", big_t'(job_ready), big_t'(1));
    chk("reset_res_data", big_t'(res_data), big_t'(0));
    submit(a1, a1, 2, 8, 0);
    finish_job();
    chk("basic_r00", big_t'(res_data[0][0]), big_t'(5));
    chk("basic_r44", big_t'(res_data[4][4]), big_t'(181));
    chk("basic_err", big_t'(res_err), big_t'(0));
    chk("basic_load_cnt", big_t'(load_cnt), big_t'(1));
    chk("basic_load_at", big_t'(load_cyc - t), big_t'(1));
    chk("basic_start_cnt", big_t'(start_cnt), big_t'(6));
    chk("basic_latency", big_t'(rv_cyc - t), big_t'(13));
    submit(a2, b2, 3, 6, 20);
    v2 = v;
    while (cyc < v2 + 5) tick();
    chk("bp_job_ready", big_t'(job_ready), big_t'(0));
    chk("bp_res_valid", big_t'(res_valid), big_t'(1));
    submit(a1, b2, 1, 1, 0);
    finish_job();
    chk("bp_load_gap", big_t'(load_cyc - v2), big_t'(22));
    chk("fast_latency", big_t'(rv_cyc - t), big_t'(9));
    submit(b2, a2, H + 10, 5, 0);
    finish_job();
    chk("slow_latency", big_t'(rv_cyc - t), big_t'(24));
    submit(a2, a2, 3, 4, 0);
    repeat (3) tick();
    chk("rst_in_start", big_t'(fa_start_comp), big_t'(1));
    reset = 1'b1;
    act = 1'b0;
    res_prev = '0;
    res_new = '0;
    ops_a = '0;
    ops_b = '0;
    exp_err = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_job_ready", big_t'(job_ready), big_t'(1));
    chk("rst_busy", big_t'(busy), big_t'(0));
    chk("rst_start", big_t'(fa_start_comp), big_t'(0));
    chk("rst_res_data", big_t'(res_data), big_t'(0));
    submit(a6, a1, 0, 3, 2);
    finish_job();
    chk("fresh_r23", big_t'(res_data[2][3]), big_t'(652));
    chk("fresh_err", big_t'(res_err), big_t'(0));
`ifdef SEQ_TIMEOUT_EN
    submit(a1, a2, 1000000, 0, 0);
    finish_job();
    chk("timeout_latency", big_t'(rv_cyc - t), big_t'(72));
    chk("timeout_err", big_t'(res_err), big_t'(1));
    chk("timeout_r23", big_t'(res_data[2][3]), big_t'(652));
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
